// File: rtl/m2p_gray_counter_ifc.sv
// Method-to-pipe marshaller for GrayCounterIfc: serializes action calls into tagged
// pipe messages and serves readGray/readBin from a cache refreshed over a return pipe.
module m2p_gray_counter_ifc #(
   parameter int width  = 4,
   parameter int TAG_W  = 16,
   parameter int DATA_W = 128,
   parameter int DEPTH  = 2
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    increment__ENA,
   output logic                    increment__RDY,
   input  logic                    decrement__ENA,
   output logic                    decrement__RDY,
   input  logic                    writeGray__ENA,
   input  logic [width-1:0]        writeGray_v,
   output logic                    writeGray__RDY,
   input  logic                    writeBin__ENA,
   input  logic [width-1:0]        writeBin_v,
   output logic                    writeBin__RDY,
   output logic [width-1:0]        readGray,
   output logic                    readGray__RDY,
   output logic [width-1:0]        readBin,
   output logic                    readBin__RDY,
   output logic                    pipe_enq__ENA,
   output logic [TAG_W+DATA_W-1:0] pipe_enq_v,
   input  logic                    pipe_enq__RDY,
   input  logic                    returnInd_enq__ENA,
   input  logic [TAG_W+DATA_W-1:0] returnInd_enq_v,
   output logic                    returnInd_enq__RDY
);
   localparam int MSG_W = TAG_W + DATA_W;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [TAG_W-1:0] TAG_INC   = TAG_W'(0);
   localparam logic [TAG_W-1:0] TAG_DEC   = TAG_W'(1);
   localparam logic [TAG_W-1:0] TAG_RGRAY = TAG_W'(2);
   localparam logic [TAG_W-1:0] TAG_WGRAY = TAG_W'(3);
   localparam logic [TAG_W-1:0] TAG_RBIN  = TAG_W'(4);
   localparam logic [TAG_W-1:0] TAG_WBIN  = TAG_W'(5);
   localparam logic [DATA_W-1:0] ZERO_PL  = '0;

   typedef enum logic [1:0] {S_IDLE, S_REQ_GRAY, S_REQ_BIN, S_WAIT} state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_count;
   logic [PTR_W-1:0]   r_head;
   logic [PTR_W-1:0]   r_tail;
   logic [MSG_W-1:0]   r_mem [DEPTH];
   logic [width-1:0]   r_grayCache;
   logic [width-1:0]   r_binCache;
   logic               r_grayValid;
   logic               r_binValid;
   logic               r_gotGray;
   logic               r_gotBin;

   logic               w_canPush;
   logic               w_pop;
   logic               w_actRdy;
   logic               w_fire;
   logic               w_push;
   logic [MSG_W-1:0]   w_actMsg;
   logic [MSG_W-1:0]   w_pushMsg;
   logic [TAG_W-1:0]   w_respTag;
   logic               w_respGray;
   logic               w_respBin;
   logic               w_unusedRespBits;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Push eligibility uses the count before this cycle's pop, so a full FIFO never bypasses.
   assign w_canPush = (r_count < FULL_CNT);
   assign w_pop     = (r_count != '0) && pipe_enq__RDY;
   assign w_actRdy  = (r_state == S_IDLE) && w_canPush;
   assign w_fire    = w_actRdy &&
                      (increment__ENA || decrement__ENA || writeGray__ENA || writeBin__ENA);

   assign w_respTag        = returnInd_enq_v[MSG_W-1:DATA_W];
   assign w_respGray       = returnInd_enq__ENA && (w_respTag == TAG_RGRAY);
   assign w_respBin        = returnInd_enq__ENA && (w_respTag == TAG_RBIN);
   assign w_unusedRespBits = ^returnInd_enq_v[DATA_W-1:width];

   always_comb begin
      w_actMsg = '0;
      if (increment__ENA)
         w_actMsg = {TAG_INC, ZERO_PL};
      else if (decrement__ENA)
         w_actMsg = {TAG_DEC, ZERO_PL};
      else if (writeGray__ENA)
         w_actMsg = {TAG_WGRAY, DATA_W'(writeGray_v)};
      else if (writeBin__ENA)
         w_actMsg = {TAG_WBIN, DATA_W'(writeBin_v)};
   end

   always_comb begin
      w_push    = 1'b0;
      w_pushMsg = '0;
      case (r_state)
         S_IDLE: begin
            w_push    = w_fire;
            w_pushMsg = w_actMsg;
         end
         S_REQ_GRAY: begin
            w_push    = w_canPush;
            w_pushMsg = {TAG_RGRAY, ZERO_PL};
         end
         S_REQ_BIN: begin
            w_push    = w_canPush;
            w_pushMsg = {TAG_RBIN, ZERO_PL};
         end
         default: begin
            w_push    = 1'b0;
            w_pushMsg = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_count <= '0;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_tail] <= w_pushMsg;
            r_tail        <= nextPtr(r_tail);
         end
         if (w_pop)
            r_head <= nextPtr(r_head);
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (!w_push && w_pop)
            r_count <= r_count - 1'b1;
      end
   end

   // Later assignments override the response updates: an accepted action's invalidation wins.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= S_REQ_GRAY;
         r_grayCache <= '0;
         r_binCache  <= '0;
         r_grayValid <= 1'b0;
         r_binValid  <= 1'b0;
         r_gotGray   <= 1'b0;
         r_gotBin    <= 1'b0;
      end else begin
         if (w_respGray) begin
            r_grayCache <= returnInd_enq_v[width-1:0];
            r_grayValid <= 1'b1;
            r_gotGray   <= 1'b1;
         end
         if (w_respBin) begin
            r_binCache <= returnInd_enq_v[width-1:0];
            r_binValid <= 1'b1;
            r_gotBin   <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (w_fire) begin
                  r_state     <= S_REQ_GRAY;
                  r_grayValid <= 1'b0;
                  r_binValid  <= 1'b0;
                  r_gotGray   <= 1'b0;
                  r_gotBin    <= 1'b0;
               end
            end
            S_REQ_GRAY: if (w_canPush) r_state <= S_REQ_BIN;
            S_REQ_BIN:  if (w_canPush) r_state <= S_WAIT;
            S_WAIT: begin
               if (r_gotGray && r_gotBin) begin
                  r_state   <= S_IDLE;
                  r_gotGray <= 1'b0;
                  r_gotBin  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign increment__RDY     = w_actRdy && !RST;
   assign decrement__RDY     = w_actRdy && !RST;
   assign writeGray__RDY     = w_actRdy && !RST;
   assign writeBin__RDY      = w_actRdy && !RST;
   assign pipe_enq__ENA      = (r_count != '0) && !RST;
   assign pipe_enq_v         = RST ? '0 : r_mem[r_head];
   assign readGray           = RST ? '0 : r_grayCache;
   assign readGray__RDY      = r_grayValid && !RST;
   assign readBin            = RST ? '0 : r_binCache;
   assign readBin__RDY       = r_binValid && !RST;
   assign returnInd_enq__RDY = 1'b1;

endmodule

// File: tb/tb_m2p_gray_counter_ifc.sv
// Self-checking bench for m2p_gray_counter_ifc: directed scenarios then random traffic,
// compared every cycle against a queue-based reference model.
module tb_m2p_gray_counter_ifc;
   localparam int WIDTH  = 4;
   localparam int DEPTH  = 2;
   localparam int MSG_W  = 144;

   logic              clock = 1'b0;
   logic              reset;
   logic              inc, dec, wg, wb;
   logic [WIDTH-1:0]  wgV, wbV;
   logic              incRdy, decRdy, wgRdy, wbRdy;
   logic [WIDTH-1:0]  grayVal, binVal;
   logic              grayRdy, binRdy;
   logic              pipeEna, pipeRdy;
   logic [MSG_W-1:0]  pipeV;
   logic              retEna, retRdy;
   logic [MSG_W-1:0]  retV;

   int testCount = 0;
   int failCount = 0;

   logic [MSG_W-1:0]  mFifo[$];
   int                mReqs[$];
   bit                mBusy;
   bit                mGotG, mGotB, mValidG, mValidB;
   logic [WIDTH-1:0]  mCacheG, mCacheB;

   m2p_gray_counter_ifc #(.width(WIDTH), .TAG_W(16), .DATA_W(128), .DEPTH(DEPTH)) dut (
      .CLK(clock), .RST(reset),
      .increment__ENA(inc), .increment__RDY(incRdy),
      .decrement__ENA(dec), .decrement__RDY(decRdy),
      .writeGray__ENA(wg), .writeGray_v(wgV), .writeGray__RDY(wgRdy),
      .writeBin__ENA(wb), .writeBin_v(wbV), .writeBin__RDY(wbRdy),
      .readGray(grayVal), .readGray__RDY(grayRdy),
      .readBin(binVal), .readBin__RDY(binRdy),
      .pipe_enq__ENA(pipeEna), .pipe_enq_v(pipeV), .pipe_enq__RDY(pipeRdy),
      .returnInd_enq__ENA(retEna), .returnInd_enq_v(retV), .returnInd_enq__RDY(retRdy)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [MSG_W-1:0] obs,
                              input logic [MSG_W-1:0] exp);
      testCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: pending refresh requests are a to-do list, the FIFO a plain queue.
   task automatic modelStep();
      int   cnt;
      bit   canPush, fired, oldG, oldB;
      logic [MSG_W-1:0] msg;
      logic [15:0] rTag;
      if (reset) begin
         mFifo.delete();
         mReqs = '{2, 4};
         mBusy = 1; mGotG = 0; mGotB = 0; mValidG = 0; mValidB = 0;
         mCacheG = '0; mCacheB = '0;
         return;
      end
      cnt = mFifo.size();
      canPush = (cnt < DEPTH);
      fired = 0;
      msg = '0;
      oldG = mGotG; oldB = mGotB;
      if (!mBusy && canPush && (inc || dec || wg || wb)) begin
         fired = 1;
         if (inc)     msg = {16'd0, 128'd0};
         else if (dec) msg = {16'd1, 128'd0};
         else if (wg)  msg = {16'd3, 124'd0, wgV};
         else          msg = {16'd5, 124'd0, wbV};
      end
      rTag = retV[143:128];
      if (retEna && rTag == 16'd2) begin mCacheG = retV[WIDTH-1:0]; mValidG = 1; mGotG = 1; end
      if (retEna && rTag == 16'd4) begin mCacheB = retV[WIDTH-1:0]; mValidB = 1; mGotB = 1; end
      if (cnt != 0 && pipeRdy) void'(mFifo.pop_front());
      if (fired) begin
         mFifo.push_back(msg);
         mValidG = 0; mValidB = 0; mGotG = 0; mGotB = 0;
         mReqs = '{2, 4};
         mBusy = 1;
      end else if (mBusy && mReqs.size() != 0) begin
         if (canPush) mFifo.push_back({16'(mReqs.pop_front()), 128'd0});
      end else if (mBusy && oldG && oldB) begin
         mBusy = 0; mGotG = 0; mGotB = 0;
      end
   endtask

   task automatic checkAll();
      bit ar;
      ar = !reset && !mBusy && (mFifo.size() < DEPTH);
      checkOutput("incRdy", incRdy, ar);
      checkOutput("decRdy", decRdy, ar);
      checkOutput("wgRdy", wgRdy, ar);
      checkOutput("wbRdy", wbRdy, ar);
      checkOutput("pipeEna", pipeEna, !reset && mFifo.size() != 0);
      if (!reset && mFifo.size() != 0) checkOutput("pipeMsg", pipeV, mFifo[0]);
      checkOutput("grayRdy", grayRdy, !reset && mValidG);
      checkOutput("binRdy", binRdy, !reset && mValidB);
      if (reset) begin
         checkOutput("pipeVRst", pipeV, '0);
         checkOutput("grayRst", grayVal, '0);
         checkOutput("binRst", binVal, '0);
      end else begin
         if (mValidG) checkOutput("grayVal", grayVal, mCacheG);
         if (mValidB) checkOutput("binVal", binVal, mCacheB);
      end
      checkOutput("retRdy", retRdy, 1'b1);
   endtask

   task automatic applyStimulus(input int n);
      repeat (n) begin
         modelStep();
         @(posedge clock);
         @(negedge clock);
         checkAll();
      end
   endtask

   task automatic respond(input int tag, input logic [127:0] pl);
      retEna = 1'b1;
      retV   = {16'(tag), pl};
      applyStimulus(1);
      retEna = 1'b0;
      retV   = '0;
   endtask

   initial begin
      reset = 1; inc = 0; dec = 0; wg = 0; wb = 0; wgV = '0; wbV = '0;
      pipeRdy = 1; retEna = 0; retV = '0;
      @(negedge clock);
      applyStimulus(2);
      reset = 0;

      // Automatic refresh after reset: tag 2 then tag 4.
      applyStimulus(1);
      checkOutput("firstTag", pipeV[143:128], 16'd2);
      applyStimulus(1);
      checkOutput("secondTag", pipeV[143:128], 16'd4);
      applyStimulus(1);
      respond(2, 128'd5);
      respond(4, 128'd6);
      applyStimulus(1);
      checkOutput("initGray", grayVal, 4'd5);
      checkOutput("initBin", binVal, 4'd6);
      checkOutput("idleRdy", incRdy, 1'b1);

      // writeBin then refresh; binary cache invalid until its response.
      wb = 1; wbV = 4'hA;
      applyStimulus(1);
      wb = 0;
      checkOutput("wbMsg", pipeV, {16'd5, 128'hA});
      checkOutput("wbInval", binRdy, 1'b0);
      applyStimulus(3);
      respond(2, 128'd9);
      checkOutput("binStillInval", binRdy, 1'b0);
      respond(4, 128'd3);
      applyStimulus(1);
      checkOutput("wbBin", binVal, 4'd3);

      // Backpressure: FIFO fills with tags 0 and 2, FSM stalls.
      pipeRdy = 0; inc = 1;
      applyStimulus(1);
      inc = 0;
      applyStimulus(4);
      checkOutput("stallRdy", incRdy, 1'b0);
      checkOutput("stallHead", pipeV[143:128], 16'd0);
      pipeRdy = 1;
      applyStimulus(1);
      checkOutput("drain2", pipeV[143:128], 16'd2);
      applyStimulus(1);
      checkOutput("drain4", pipeV[143:128], 16'd4);
      applyStimulus(1);
      respond(4, 128'd1);
      respond(2, 128'd2);
      applyStimulus(1);

      // Simultaneous increment and writeGray: increment wins, writeGray is dropped.
      inc = 1; wg = 1; wgV = 4'h7;
      applyStimulus(1);
      inc = 0; wg = 0;
      checkOutput("prioMsg", pipeV, {16'd0, 128'd0});
      applyStimulus(3);
      respond(7, 128'd3);
      checkOutput("tag7Wait", incRdy, 1'b0);
      checkOutput("tag7Gray", grayRdy, 1'b0);
      respond(2, 128'hF);
      respond(4, 128'hE);
      applyStimulus(1);

      // Reset mid-operation with queued messages.
      pipeRdy = 0; dec = 1;
      applyStimulus(1);
      dec = 0;
      applyStimulus(2);
      reset = 1;
      applyStimulus(1);
      reset = 0; pipeRdy = 1;
      checkOutput("rstEna", pipeEna, 1'b0);
      applyStimulus(1);
      checkOutput("rstRestart", pipeV[143:128], 16'd2);

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         reset   = ($urandom_range(0, 299) == 0);
         pipeRdy = ($urandom_range(0, 3) != 0);
         inc = ($urandom_range(0, 7) == 0);
         dec = ($urandom_range(0, 7) == 0);
         wg  = ($urandom_range(0, 7) == 0);
         wb  = ($urandom_range(0, 7) == 0);
         wgV = WIDTH'($urandom);
         wbV = WIDTH'($urandom);
         retEna = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 4))
            0, 1:    retV[143:128] = 16'd2;
            2, 3:    retV[143:128] = 16'd4;
            default: retV[143:128] = 16'($urandom);
         endcase
         retV[127:0] = {$urandom, $urandom, $urandom, $urandom};
         applyStimulus(1);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end
endmodule
